// File: rtl/multiplier_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : multiplier_if                                               |
// | Purpose : Request/result bundle for the shift-add multiplier.         |
// |           master : drives sclr, start, a_in, b_in; reads results.     |
// |           slave  : the multiplier side.                               |
// | Signals : sclr   - synchronous clear, active-high                     |
// |           start  - request pulse, sampled only in IDLE                |
// |           a_in   - 10-bit unsigned multiplicand                       |
// |           b_in   - 10-bit unsigned multiplier                         |
// |           p_out  - 20-bit product, held until next accepted start     |
// |           ovf    - product does not fit in 10 bits                    |
// |           busy   - multiplication in progress                         |
// |           valid  - one-cycle pulse marking p_out/ovf final            |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
interface multiplier_if;
   logic        sclr;
   logic        start;
   logic [9:0]  a_in;
   logic [9:0]  b_in;
   logic [19:0] p_out;
   logic        ovf;
   logic        busy;
   logic        valid;

   modport master (
      output sclr, start, a_in, b_in,
      input  p_out, ovf, busy, valid
   );

   modport slave (
      input  sclr, start, a_in, b_in,
      output p_out, ovf, busy, valid
   );
endinterface
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : multiplier                                                  |
// | Purpose : 10x10 unsigned sequential multiplier, one multiplier bit    |
// |           per clock (LSB first shift-add), with zero early-out.       |
// | Ports   : clk   - rising-edge clock                                   |
// |           rst_n - asynchronous active-low reset                       |
// |           bus   - multiplier_if.slave (sclr, start, a_in, b_in,       |
// |                   p_out, ovf, busy, valid)                            |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module multiplier (
   input  wire          clk,
   input  wire          rst_n,
   multiplier_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  a_q, a_d;        // latched multiplicand
   logic [19:0] acc_q, acc_d;    // [19:10] partial product, [9:0] remaining multiplier bits
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] p_out_q, p_out_d;
   logic        ovf_q, ovf_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;

   logic [10:0] add_sum;         // carry kept in bit 10
   logic [19:0] shift_acc;

   always_comb begin
      add_sum   = {1'b0, acc_q[19:10]} + {1'b0, a_q};
      // The carry drops into bit 19 as the whole accumulator shifts right.
      shift_acc = acc_q[0] ? {add_sum, acc_q[9:1]} : {1'b0, acc_q[19:1]};

      state_d = state_q;
      a_d     = a_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_out_d = p_out_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      valid_d = 1'b0;

      if (bus.sclr) begin
         state_d = S_IDLE;
         a_d     = '0;
         acc_d   = '0;
         cnt_d   = '0;
         p_out_d = '0;
         ovf_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  a_d     = bus.a_in;
                  acc_d   = {10'd0, bus.b_in};
                  cnt_d   = '0;
                  p_out_d = '0;
                  ovf_d   = 1'b0;
                  if (bus.a_in == 10'd0 || bus.b_in == 10'd0) begin
                     // Product is known to be zero: skip CALC entirely.
                     state_d = S_DONE;
                     valid_d = 1'b1;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = S_CALC;
                     busy_d  = 1'b1;
                  end
               end
            end
            S_CALC: begin
               acc_d = shift_acc;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd9) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                  p_out_d = shift_acc;
                  ovf_d   = |shift_acc[19:10];
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_out_q <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_out_q <= p_out_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign bus.p_out = p_out_q;
   assign bus.ovf   = ovf_q;
   assign bus.busy  = busy_q;
   assign bus.valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_multiplier                                               |
// | Purpose : Self-checking bench for multiplier: directed corner cases   |
// |           plus random operands against an arithmetic reference.      |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_multiplier;

   logic clk;
   logic rst_n;
   int   chk_cnt;
   int   pass_cnt;
   int   fail_cnt;
   int   vcount;

   multiplier_if u_if ();

   multiplier dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every cycle with valid high counts as one pulse cycle.
   always @(negedge clk) if (u_if.valid === 1'b1) vcount = vcount + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt = chk_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else begin
         fail_cnt = fail_cnt + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_p"},     u_if.p_out, 0);
      check({tag, "_ovf"},   u_if.ovf,   0);
      check({tag, "_busy"},  u_if.busy,  0);
      check({tag, "_valid"}, u_if.valid, 0);
   endtask

   // Issue one request and check it to completion against a*b.
   // disturb: toggle start and change operands in the middle of CALC.
   task automatic run_op(input logic [9:0] a, input logic [9:0] b, input bit disturb);
      logic [19:0] exp_p;
      logic        exp_ovf;
      int          n;
      int          v0;
      exp_p   = 20'(a) * 20'(b);
      exp_ovf = (exp_p > 20'd1023);
      v0      = vcount;
      @(negedge clk);
      u_if.a_in  = a;
      u_if.b_in  = b;
      u_if.start = 1'b1;
      @(posedge clk);   // E0
      #1;
      u_if.start = 1'b0;
      if (a == 0 || b == 0) begin
         check("zero_busy",  u_if.busy,  0);
         check("zero_valid", u_if.valid, 1);
         check("zero_p",     u_if.p_out, 0);
         check("zero_ovf",   u_if.ovf,   0);
         @(posedge clk); #1;
         check("zero_busy2", u_if.busy,  0);
         check("zero_valid2", u_if.valid, 0);
      end else begin
         n = 0;
         while (u_if.busy === 1'b1 && n < 30) begin
            n = n + 1;
            if (disturb && n == 3) begin
               u_if.start = 1'b1;
               u_if.a_in  = 10'd1000;
               u_if.b_in  = 10'd999;
            end
            if (disturb && n == 4) u_if.start = 1'b0;
            @(posedge clk); #1;
         end
         check("busy_cycles", n, 10);
         check("valid",       u_if.valid, 1);
         check("product",     u_if.p_out, exp_p);
         check("ovf",         u_if.ovf,   exp_ovf);
         @(posedge clk); #1;
         check("valid_drop",  u_if.valid, 0);
         check("busy_after",  u_if.busy,  0);
      end
      @(posedge clk); #1;
      check("hold_p",       u_if.p_out, exp_p);
      check("hold_ovf",     u_if.ovf,   exp_ovf);
      check("hold_valid",   u_if.valid, 0);
      check("valid_pulses", vcount - v0, 1);
   endtask

   initial begin
      int v0;
      chk_cnt  = 0;
      pass_cnt = 0;
      fail_cnt = 0;
      vcount   = 0;
      rst_n      = 1'b0;
      u_if.sclr  = 1'b0;
      u_if.start = 1'b0;
      u_if.a_in  = '0;
      u_if.b_in  = '0;

      // Reset state, observed before any clock edge and after a few.
      #2;
      check_idle_zero("rst_noclk");
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      run_op(10'd25,   10'd40,   1'b0);
      run_op(10'd1023, 10'd1023, 1'b0);
      run_op(10'd0,    10'd517,  1'b0);
      run_op(10'd517,  10'd0,    1'b0);
      run_op(10'd3,    10'd7,    1'b1);
      run_op(10'd1,    10'd1023, 1'b0);
      run_op(10'd32,   10'd32,   1'b0);
      run_op(10'd33,   10'd31,   1'b0);

      // Random operands.
      for (int i = 0; i < 10; i++) begin
         run_op(10'($urandom_range(0, 1023)), 10'($urandom_range(1, 1023)), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset once the counter has reached 4.
      v0 = vcount;
      @(negedge clk);
      u_if.a_in  = 10'd600;
      u_if.b_in  = 10'd700;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_zero("arst_now");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("arst_after");
      check("arst_no_valid", vcount - v0, 0);
      run_op(10'd25, 10'd40, 1'b0);

      // Synchronous clear from idle with a held non-zero product.
      @(negedge clk);
      u_if.sclr = 1'b1;
      @(posedge clk); #1;
      u_if.sclr = 1'b0;
      check_idle_zero("sclr_idle");

      // Synchronous clear mid-CALC, then clear together with start.
      v0 = vcount;
      @(negedge clk);
      u_if.a_in  = 10'd511;
      u_if.b_in  = 10'd300;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      u_if.sclr = 1'b1;
      @(posedge clk); #1;
      check_idle_zero("sclr_calc");
      u_if.start = 1'b1;
      @(posedge clk); #1;
      u_if.sclr  = 1'b0;
      u_if.start = 1'b0;
      check_idle_zero("sclr_start");
      repeat (12) @(posedge clk);
      #1;
      check_idle_zero("sclr_later");
      check("sclr_no_valid", vcount - v0, 0);

      run_op(10'd3, 10'd7, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
